// File: rtl/baud_gen_prog.sv
// Programmable UART baud generator: prescaler -> oversample counter, producing
// os_tick, baud_tick and a 50% baud_clk, with boundary-aligned divisor updates.
module baud_gen_prog #(
  parameter int DIV_W       = 16,
  parameter int OVERSAMPLE  = 16,
  parameter int DEFAULT_DIV = 27
) (
  input  logic             clock_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_restart,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic             os_tick,
  output logic             baud_tick,
  output logic             baud_clk,
  output logic             div_pending
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_DEF  = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic [DIV_W-1:0] div_reg_q, div_reg_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             div_pending_q, div_pending_d;
  logic             os_tick_q, os_tick_d;
  logic             baud_tick_q, baud_tick_d;
  logic             baud_clk_q, baud_clk_d;

  logic pre_wrap;
  logic baud_wrap;
  logic apply_pend;

  assign pre_wrap  = en && (pre_cnt_q == (div_reg_q - DIV_ONE));
  assign baud_wrap = pre_wrap && (os_cnt_q == OS_LAST);
  // A load on the same edge wins: the older pending value is dropped unapplied.
  assign apply_pend = div_pending_q && !div_load && (sync_restart || !en || baud_wrap);

  always_comb begin
    pre_cnt_d     = pre_cnt_q;
    os_cnt_d      = os_cnt_q;
    div_reg_d     = div_reg_q;
    pend_div_d    = pend_div_q;
    div_pending_d = div_pending_q;
    os_tick_d     = 1'b0;
    baud_tick_d   = 1'b0;

    if (sync_restart) begin
      pre_cnt_d = '0;
      os_cnt_d  = '0;
    end else if (en) begin
      if (pre_wrap) begin
        pre_cnt_d = '0;
        os_tick_d = 1'b1;
        if (baud_wrap) begin
          os_cnt_d    = '0;
          baud_tick_d = 1'b1;
        end else begin
          os_cnt_d = os_cnt_q + OS_W'(1);
        end
      end else begin
        pre_cnt_d = pre_cnt_q + DIV_ONE;
      end
    end

    if (apply_pend) begin
      div_reg_d = pend_div_q;
      pre_cnt_d = '0;
    end

    if (div_load) begin
      pend_div_d    = (div_value == '0) ? DIV_ONE : div_value;
      div_pending_d = 1'b1;
    end else if (apply_pend) begin
      div_pending_d = 1'b0;
    end

    baud_clk_d = (os_cnt_d >= OS_HALF);
  end

  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q     <= '0;
      os_cnt_q      <= '0;
      div_reg_q     <= DIV_DEF;
      pend_div_q    <= '0;
      div_pending_q <= 1'b0;
      os_tick_q     <= 1'b0;
      baud_tick_q   <= 1'b0;
      baud_clk_q    <= 1'b0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      os_cnt_q      <= os_cnt_d;
      div_reg_q     <= div_reg_d;
      pend_div_q    <= pend_div_d;
      div_pending_q <= div_pending_d;
      os_tick_q     <= os_tick_d;
      baud_tick_q   <= baud_tick_d;
      baud_clk_q    <= baud_clk_d;
    end
  end

  assign os_tick     = os_tick_q;
  assign baud_tick   = baud_tick_q;
  assign baud_clk    = baud_clk_q;
  assign div_pending = div_pending_q;

endmodule

// File: tb/tb_baud_gen_prog.sv
// Directed bench for baud_gen_prog with DEFAULT_DIV=2, OVERSAMPLE=16.
module tb_baud_gen_prog;

  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             sync_restart = 1'b0;
  logic             div_load = 1'b0;
  logic [DIV_W-1:0] div_value = '0;
  logic             os_tick, baud_tick, baud_clk, div_pending;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  baud_gen_prog #(.DIV_W(DIV_W), .OVERSAMPLE(16), .DEFAULT_DIV(2)) dut (
    .clock_in    (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sync_restart(sync_restart),
    .div_load    (div_load),
    .div_value   (div_value),
    .os_tick     (os_tick),
    .baud_tick   (baud_tick),
    .baud_clk    (baud_clk),
    .div_pending (div_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    en = 1'b0; sync_restart = 1'b0; div_load = 1'b0; div_value = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (os_tick !== 1'b0) begin errors++; $display("FAIL reset_os_tick got=%b exp=0", os_tick); end
    checks++; if (baud_tick !== 1'b0) begin errors++; $display("FAIL reset_baud_tick got=%b exp=0", baud_tick); end
    checks++; if (baud_clk !== 1'b0) begin errors++; $display("FAIL reset_baud_clk got=%b exp=0", baud_clk); end
    checks++; if (div_pending !== 1'b0) begin errors++; $display("FAIL reset_div_pending got=%b exp=0", div_pending); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic eo, eb, ec;
    do_reset();
    en = 1'b1;
    for (int n = 1; n <= 64; n++) begin
      step();
      eo = (n % 2 == 0);
      eb = (n % 32 == 0);
      ec = ((n % 32) >= 16);
      checks++; if (os_tick !== eo) begin errors++; $display("FAIL basic_os_tick cyc=%0d got=%b exp=%b", n, os_tick, eo); end
      checks++; if (baud_tick !== eb) begin errors++; $display("FAIL basic_baud_tick cyc=%0d got=%b exp=%b", n, baud_tick, eb); end
      checks++; if (baud_clk !== ec) begin errors++; $display("FAIL basic_baud_clk cyc=%0d got=%b exp=%b", n, baud_clk, ec); end
    end
    $display("test_basic done cycles=%0d", cyc);
  endtask

  task automatic test_runtime_load();
    logic eo, eb, ec, ep;
    do_reset();
    en = 1'b1;
    for (int n = 1; n <= 96; n++) begin
      if (n == 11) begin div_load = 1'b1; div_value = 16'd4; end
      step();
      div_load = 1'b0;
      if (n <= 32) begin
        eo = (n % 2 == 0);
        eb = (n % 32 == 0);
        ec = ((n % 32) >= 16);
      end else begin
        eo = ((n - 32) % 4 == 0);
        eb = (n == 96);
        ec = (((n - 32) % 64) >= 32);
      end
      ep = (n >= 11 && n < 32);
      checks++; if (os_tick !== eo) begin errors++; $display("FAIL load_os_tick cyc=%0d got=%b exp=%b", n, os_tick, eo); end
      checks++; if (baud_tick !== eb) begin errors++; $display("FAIL load_baud_tick cyc=%0d got=%b exp=%b", n, baud_tick, eb); end
      checks++; if (baud_clk !== ec) begin errors++; $display("FAIL load_baud_clk cyc=%0d got=%b exp=%b", n, baud_clk, ec); end
      checks++; if (div_pending !== ep) begin errors++; $display("FAIL load_div_pending cyc=%0d got=%b exp=%b", n, div_pending, ep); end
    end
    $display("test_runtime_load done");
  endtask

  task automatic test_en_toggle();
    logic eo, eb, ec;
    int k = 0;
    int os_count = 0;
    do_reset();
    div_load = 1'b1; div_value = 16'd3;
    step();
    div_load = 1'b0;
    checks++; if (div_pending !== 1'b1) begin errors++; $display("FAIL toggle_pend_set got=%b exp=1", div_pending); end
    step();
    checks++; if (div_pending !== 1'b0) begin errors++; $display("FAIL toggle_pend_applied got=%b exp=0", div_pending); end
    for (int e = 0; e < 55; e++) begin
      en = !(e >= 20 && e < 27);
      step();
      if (en) begin
        k++;
        eo = (k % 3 == 0);
        eb = (k % 48 == 0);
      end else begin
        eo = 1'b0;
        eb = 1'b0;
      end
      ec = ((k % 48) >= 24);
      if (os_tick === 1'b1) os_count++;
      checks++; if (os_tick !== eo) begin errors++; $display("FAIL toggle_os_tick e=%0d k=%0d got=%b exp=%b", e, k, os_tick, eo); end
      checks++; if (baud_tick !== eb) begin errors++; $display("FAIL toggle_baud_tick e=%0d k=%0d got=%b exp=%b", e, k, baud_tick, eb); end
      checks++; if (baud_clk !== ec) begin errors++; $display("FAIL toggle_baud_clk e=%0d k=%0d got=%b exp=%b", e, k, baud_clk, ec); end
    end
    checks++; if (os_count != 16) begin errors++; $display("FAIL toggle_os_count got=%0d exp=16", os_count); end
    $display("test_en_toggle done enabled=%0d os_ticks=%0d", k, os_count);
  endtask

  task automatic test_sync_restart();
    logic eo, eb, ec;
    do_reset();
    en = 1'b1;
    repeat (19) step();
    checks++; if (baud_clk !== 1'b1) begin errors++; $display("FAIL sync_pre_baud_clk got=%b exp=1", baud_clk); end
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    checks++; if (os_tick !== 1'b0) begin errors++; $display("FAIL sync_os_tick got=%b exp=0", os_tick); end
    checks++; if (baud_clk !== 1'b0) begin errors++; $display("FAIL sync_baud_clk got=%b exp=0", baud_clk); end
    for (int n = 21; n <= 52; n++) begin
      step();
      eo = ((n - 20) % 2 == 0);
      eb = (n == 52);
      ec = ((((n - 20) / 2) % 16) >= 8);
      checks++; if (os_tick !== eo) begin errors++; $display("FAIL sync_os_tick cyc=%0d got=%b exp=%b", n, os_tick, eo); end
      checks++; if (baud_tick !== eb) begin errors++; $display("FAIL sync_baud_tick cyc=%0d got=%b exp=%b", n, baud_tick, eb); end
      checks++; if (baud_clk !== ec) begin errors++; $display("FAIL sync_baud_clk cyc=%0d got=%b exp=%b", n, baud_clk, ec); end
    end
    div_load = 1'b1; div_value = 16'd5;
    step();
    div_load = 1'b0;
    checks++; if (div_pending !== 1'b1) begin errors++; $display("FAIL sync_pend_set got=%b exp=1", div_pending); end
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    checks++; if (div_pending !== 1'b0) begin errors++; $display("FAIL sync_pend_applied got=%b exp=0", div_pending); end
    for (int n = 1; n <= 5; n++) begin
      step();
      eo = (n == 5);
      checks++; if (os_tick !== eo) begin errors++; $display("FAIL sync_div5_os_tick n=%0d got=%b exp=%b", n, os_tick, eo); end
    end
    $display("test_sync_restart done");
  endtask

  task automatic test_div_zero();
    logic eb, ec;
    do_reset();
    div_load = 1'b1; div_value = '0;
    step();
    div_load = 1'b0;
    checks++; if (div_pending !== 1'b1) begin errors++; $display("FAIL zero_pend_set got=%b exp=1", div_pending); end
    step();
    checks++; if (div_pending !== 1'b0) begin errors++; $display("FAIL zero_pend_applied got=%b exp=0", div_pending); end
    en = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      step();
      eb = (n % 16 == 0);
      ec = ((n % 16) >= 8);
      checks++; if (os_tick !== 1'b1) begin errors++; $display("FAIL zero_os_tick n=%0d got=%b exp=1", n, os_tick); end
      checks++; if (baud_tick !== eb) begin errors++; $display("FAIL zero_baud_tick n=%0d got=%b exp=%b", n, baud_tick, eb); end
      checks++; if (baud_clk !== ec) begin errors++; $display("FAIL zero_baud_clk n=%0d got=%b exp=%b", n, baud_clk, ec); end
    end
    $display("test_div_zero done");
  endtask

  task automatic test_async_reset();
    logic eo, eb;
    do_reset();
    en = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      if (n == 10) begin div_load = 1'b1; div_value = 16'd7; end
      step();
      div_load = 1'b0;
    end
    checks++; if (div_pending !== 1'b1) begin errors++; $display("FAIL arst_pre_pending got=%b exp=1", div_pending); end
    checks++; if (baud_clk !== 1'b1) begin errors++; $display("FAIL arst_pre_baud_clk got=%b exp=1", baud_clk); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (os_tick !== 1'b0) begin errors++; $display("FAIL arst_os_tick got=%b exp=0", os_tick); end
    checks++; if (baud_tick !== 1'b0) begin errors++; $display("FAIL arst_baud_tick got=%b exp=0", baud_tick); end
    checks++; if (baud_clk !== 1'b0) begin errors++; $display("FAIL arst_baud_clk got=%b exp=0", baud_clk); end
    checks++; if (div_pending !== 1'b0) begin errors++; $display("FAIL arst_div_pending got=%b exp=0", div_pending); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int n = 1; n <= 32; n++) begin
      step();
      eo = (n % 2 == 0);
      eb = (n == 32);
      checks++; if (os_tick !== eo) begin errors++; $display("FAIL arst_os_tick cyc=%0d got=%b exp=%b", n, os_tick, eo); end
      checks++; if (baud_tick !== eb) begin errors++; $display("FAIL arst_baud_tick cyc=%0d got=%b exp=%b", n, baud_tick, eb); end
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_runtime_load();
    test_en_toggle();
    test_sync_restart();
    test_div_zero();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/baud_gen_prog.md
Name: baud_gen_prog

Overview:
- Programmable UART baud generator. Produces an oversampling tick (os_tick) for the receiver sampler and a baud tick (baud_tick) for the transmitter shifter.
- Also produces a baud-rate square wave, baud_clk, for legacy consumers.
- The divisor can be changed at runtime. Changes are glitch-free and take effect only on a baud boundary.
- Counters can be re-phased mid-frame (sync_restart) so the RX start-bit edge aligns the sample grid.

Parameters:
- DIV_W, 16, width of the prescaler divisor and its counter.
- OVERSAMPLE, 16, os_ticks per baud period; must be an even value, 4..256.
- DEFAULT_DIV, 27, divisor loaded at reset; must be in 1..2^DIV_W-1.

Ports:
- clock_in  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; when low, all counters hold.
- sync_restart  input  1  one-cycle pulse; zeroes the prescaler and oversample counters.
- div_load  input  1  one-cycle pulse; captures div_value into the pending register.
- div_value  input  DIV_W  new divisor; 0 is treated as 1.
- os_tick  output  1  one-cycle pulse every div_reg enabled cycles.
- baud_tick  output  1  one-cycle pulse every OVERSAMPLE os_ticks.
- baud_clk  output  1  high while os_cnt >= OVERSAMPLE/2.
- div_pending  output  1  a loaded divisor is waiting for a baud boundary.

Behaviour:
- Reset (async, rst_n=0):
  - pre_cnt=0, os_cnt=0, div_reg=DEFAULT_DIV, pend_div=0.
  - os_tick=0, baud_tick=0, baud_clk=0, div_pending=0.
- State:
  - pre_cnt [DIV_W-1:0], counts 0..div_reg-1.
  - os_cnt [$clog2(OVERSAMPLE)-1:0], counts 0..OVERSAMPLE-1.
  - div_reg, pend_div, div_pending.
- Prescaler: on each edge with en=1:
  - if pre_cnt==div_reg-1, then pre_cnt<=0 and os_tick<=1;
  - otherwise pre_cnt<=pre_cnt+1 and os_tick<=0.
- os_tick and baud_tick are registered. Each is high exactly one cycle and is 0 on any edge where en=0.
- Oversample counter: advances only on the edge where the prescaler wraps.
  - If os_cnt==OVERSAMPLE-1, then os_cnt<=0 and baud_tick<=1 on the same edge as os_tick.
  - Otherwise os_cnt<=os_cnt+1.
- baud_clk is registered and reflects (os_cnt >= OVERSAMPLE/2) using the post-edge os_cnt, giving a 50% duty cycle.
- Latency, en held high from reset release with divisor D:
  - first os_tick is high in the cycle after edge D;
  - first baud_tick is high in the cycle after edge D*OVERSAMPLE;
  - baud period is D*OVERSAMPLE cycles.
- Divisor update:
  - div_load=1 captures max(div_value,1) into pend_div and sets div_pending=1. A later load before application overwrites pend_div.
  - If en=0, the pending divisor is applied on the next edge: div_reg<=pend_div, pre_cnt<=0, div_pending<=0.
  - If en=1, it is applied on the edge that generates baud_tick; pre_cnt is already 0 at that point.
  - div_reg never changes mid-baud while en=1.
  - div_load coincident with a baud-boundary edge: the new value is captured but applied at the following boundary. The old pending value, if any, is discarded.
- sync_restart (edge where sync_restart=1):
  - pre_cnt<=0, os_cnt<=0; os_tick and baud_tick <=0 on that edge.
  - baud_clk<=0.
  - Pending divisor is applied immediately, regardless of en.
  - Overrides a simultaneous wrap.
- en deassert mid-count: counters freeze and resume from the frozen values when en returns. No tick is lost or duplicated.
- div_reg=1: os_tick is high every enabled cycle; baud_tick every OVERSAMPLE cycles.
- Reset mid-operation: all state returns to reset values asynchronously and the pending divisor is lost.

Test Plan:
- DEFAULT_DIV=2, OVERSAMPLE=16, en=1 after reset -> os_tick high on cycles 2,4,6,...; baud_tick high on cycles 32,64,...; baud_clk low for cycles 1..15 of the period and high for 16..31 (0-based cycle count from the first enabled edge).
- Runtime load: div=2, pulse div_load with div_value=4 at cycle 10 -> div_pending=1 until the cycle-32 baud_tick; next baud_tick at cycle 32+64=96, with os_tick spacing of 4 thereafter.
- en toggling: div=3, drop en for 7 cycles at cycle 20 -> every tick shifts by exactly 7 cycles, os_tick count over 48 enabled cycles is exactly 16.
- sync_restart at os_cnt=9, pre_cnt=1 (div=2) -> os_cnt=0, baud_clk=0 next cycle; next baud_tick exactly 32 cycles after the restart edge.
- div_value=0 loaded with en=0 -> div_reg=1 next cycle, div_pending=0; with en=1, os_tick is continuously high and baud_tick repeats every 16 cycles.
- rst_n asserted asynchronously between clock edges mid-period -> all outputs 0 immediately; after release, divisor=DEFAULT_DIV and the first baud_tick is at cycle DEFAULT_DIV*16.
